decade_2421_chain_ctrl: RTL and testbench

//   Controls and cascades DIGITS 2421-coded (Aiken) decade counter digits into one multi-digit event counter.

---
 rtl/decade_2421_chain_ctrl.sv | 105 ++++++++++
 tb/tb_decade_2421_chain_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/decade_2421_chain_ctrl.sv
// Run/stop sequencer for a chain of 2421 (Aiken) decade digits counting rising edges of x.
// Latency: out/z update 1 clk after the edge that samples x; no backpressure, edges outside RUN are dropped.
module decade_2421_chain_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                x,
    input  logic [4*DIGITS-1:0] target,
    output logic [4*DIGITS-1:0] out,
    output logic                z,
    output logic                done,
    output logic                busy,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t              st;
    logic                x_q;
    logic                tick;
    logic                wrap;
    logic                hit;
    logic [4*DIGITS-1:0] nxt;

    // 4 jumps straight to 5 (1011); 9 rolls to 0 and carries.
    function automatic logic [3:0] inc_2421(input logic [3:0] d);
        case (d)
            4'b0100: inc_2421 = 4'b1011;
            4'b1111: inc_2421 = 4'b0000;
            default: inc_2421 = d + 4'd1;
        endcase
    endfunction

    always_comb begin
        logic c;
        c   = 1'b1;
        nxt = out;
        for (int k = 0; k < DIGITS; k++) begin
            if (c) begin
                nxt[4*k +: 4] = inc_2421(out[4*k +: 4]);
            end
            c = c & (out[4*k +: 4] == 4'b1111);
        end
        wrap = c;
    end

    assign tick  = x & ~x_q;
    // nxt is always a valid code, so a target with an illegal digit can never hit.
    assign hit   = (nxt == target);
    assign state = st;
    assign busy  = (st == RUN);
    assign done  = (st == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            st  <= IDLE;
            out <= '0;
            z   <= 1'b0;
            x_q <= 1'b0;
        end else begin
            x_q <= x;
            z   <= 1'b0;
            if (clear) begin
                out <= '0;
                st  <= IDLE;
            end else begin
                case (st)
                    IDLE, PAUSE: begin
                        if (start) begin
                            st <= RUN;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            st <= PAUSE;
                        end else if (tick) begin
                            out <= nxt;
                            z   <= wrap;
                            if (hit) begin
                                st <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (start) begin
                            out <= '0;
                            st  <= RUN;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decade_2421_chain_ctrl.sv
// Directed bench for decade_2421_chain_ctrl with DIGITS=2 and a decimal reference model.
module tb_decade_2421_chain_ctrl;

    localparam int DIGITS = 2;

    logic                clk    = 1'b0;
    logic                reset  = 1'b0;
    logic                start  = 1'b0;
    logic                stop   = 1'b0;
    logic                clear  = 1'b0;
    logic                x      = 1'b0;
    logic [4*DIGITS-1:0] target = '0;
    logic [4*DIGITS-1:0] out;
    logic                z;
    logic                done;
    logic                busy;
    logic [1:0]          state;

    decade_2421_chain_ctrl #(.DIGITS(DIGITS)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .clear  (clear),
        .x      (x),
        .target (target),
        .out    (out),
        .z      (z),
        .done   (done),
        .busy   (busy),
        .state  (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] out;
        logic       z;
        logic [1:0] st;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         m_cnt  = 0;
    logic [1:0] m_st   = 2'b00;
    int         z_seen = 0;

    function automatic logic [3:0] d2421(input int d);
        case (d)
            0: d2421 = 4'h0;
            1: d2421 = 4'h1;
            2: d2421 = 4'h2;
            3: d2421 = 4'h3;
            4: d2421 = 4'h4;
            5: d2421 = 4'hB;
            6: d2421 = 4'hC;
            7: d2421 = 4'hD;
            8: d2421 = 4'hE;
            default: d2421 = 4'hF;
        endcase
    endfunction

    function automatic logic [7:0] enc(input int n);
        return {d2421(n / 10), d2421(n % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (z === 1'b1) z_seen++;
    endtask

    // One x edge with a 4-clk period; expectation queued before driving, popped after the sampling edge.
    task automatic pulse_x(input string tag);
        exp_t e;
        exp_t g;
        e.z = 1'b0;
        if (m_st == 2'b01) begin
            m_cnt = (m_cnt + 1) % 100;
            e.z   = (m_cnt == 0);
            if (enc(m_cnt) == target) m_st = 2'b11;
        end
        e.out = enc(m_cnt);
        e.st  = m_st;
        sb.push_back(e);
        x = 1'b1;
        cyc();
        g = sb.pop_front();
        chk({tag, "_out"}, 32'(out), 32'(g.out));
        chk({tag, "_z"}, 32'(z), 32'(g.z));
        chk({tag, "_state"}, 32'(state), 32'(g.st));
        cyc();
        x = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        if (m_st == 2'b11) m_cnt = 0;
        m_st = 2'b01;
    endtask

    initial begin
        // 1: reset with x toggling, then edges while IDLE
        reset = 1'b0;
        x = 1'b1; cyc();
        x = 1'b0; cyc();
        chk("rst_out", 32'(out), 32'h00);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_z", 32'(z), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) pulse_x("idle");

        // 2: count up to target 21, extra edges ignored in DONE
        target = 8'h21;
        do_start();
        chk("t2_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 23; i++) pulse_x("t2");
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_hold", 32'(out), 32'h21);

        // 3: invalid target, free-run through the wrap
        target = 8'h55;
        do_start();
        chk("t3_restart_out", 32'(out), 32'h00);
        chk("t3_restart_state", 32'(state), 32'h1);
        z_seen = 0;
        for (int i = 0; i < 100; i++) pulse_x("t3");
        chk("t3_z_once", 32'(z_seen), 32'd1);
        chk("t3_no_done", 32'(done), 32'h0);

        // 4: stop on an edge, then resume with x already high
        for (int i = 0; i < 3; i++) pulse_x("t4_pre");
        x = 1'b1; stop = 1'b1;
        cyc();
        stop = 1'b0;
        m_st = 2'b10;
        chk("t4_stop_out", 32'(out), 32'h03);
        chk("t4_stop_state", 32'(state), 32'h2);
        cyc();
        do_start();
        chk("t4_resume_state", 32'(state), 32'h1);
        cyc();
        cyc();
        chk("t4_level_x", 32'(out), 32'h03);
        x = 1'b0;
        cyc();
        pulse_x("t4_post");

        // 5: clear beats start and tick; reset mid-RUN
        for (int i = 0; i < 11; i++) pulse_x("t5_pre");
        chk("t5_at15", 32'(out), 32'h1B);
        clear = 1'b1; start = 1'b1; x = 1'b1;
        cyc();
        clear = 1'b0; start = 1'b0;
        m_cnt = 0; m_st = 2'b00;
        chk("t5_clr_out", 32'(out), 32'h00);
        chk("t5_clr_state", 32'(state), 32'h0);
        chk("t5_clr_z", 32'(z), 32'h0);
        x = 1'b0;
        cyc();
        do_start();
        pulse_x("t5_run");
        pulse_x("t5_run");
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        m_cnt = 0; m_st = 2'b00;
        chk("t5_rst_out", 32'(out), 32'h00);
        chk("t5_rst_state", 32'(state), 32'h0);

        // 6: DONE, restart from DONE, DONE again
        target = 8'h02;
        do_start();
        pulse_x("t6a");
        pulse_x("t6a");
        chk("t6_done1", 32'(done), 32'h1);
        do_start();
        chk("t6_restart_out", 32'(out), 32'h00);
        chk("t6_restart_state", 32'(state), 32'h1);
        pulse_x("t6b");
        pulse_x("t6b");
        chk("t6_done2", 32'(done), 32'h1);
        chk("t6_out", 32'(out), 32'h02);

        // 7: target zero hits only on the wrap, together with z
        target = 8'h00;
        do_start();
        chk("t7_no_idle_match", 32'(state), 32'h1);
        z_seen = 0;
        for (int i = 0; i < 100; i++) pulse_x("t7");
        chk("t7_done", 32'(done), 32'h1);
        chk("t7_z_once", 32'(z_seen), 32'd1);
        chk("t7_out", 32'(out), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
